data_memory_param: RTL and testbench
====================================

Name: data_memory_param

Overview:
Parametrised single-port synchronous data memory, the next generation of the 8-bit DataMemory. It adds configurable width and depth, byte-enable writes, and registered reads with a valid flag. It also adds a selectable read-during-write mode, out-of-range detection and a hardware clear engine that zeroes the array after reset or on request. The block sits between the datapath load/store unit and the storage array.

Parameters:
DW, 8, data width in bits; must be a multiple of 8
AW, 8, address width in bits
DEPTH, 256, number of words; 1 <= DEPTH <= 2**AW
RDW_MODE, 0, same-address read during write: 0 = read-first (old data), 1 = write-first (merged new data)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
adr  input  AW  word address
datain  input  DW  write data
be  input  DW/8  byte enables for writes; bit i covers datain[8i+7:8i]
w  input  1  write request; honoured only when ready=1
r  input  1  read request; honoured only when ready=1
clr  input  1  start a clear of the whole array; honoured only when ready=1
dataout  output  DW  registered read data
rvalid  output  1  one-cycle pulse; dataout holds the result of a read accepted in the previous cycle
ready  output  1  block accepts w/r/clr this cycle
busy  output  1  clear engine running
err  output  1  one-cycle pulse; the previous accepted access had adr >= DEPTH

Behaviour:
- Reset (rst_n=0, asynchronous): FSM enters INIT, clear pointer = 0, dataout = 0, rvalid = 0, err = 0, ready = 0, busy = 1. Array contents are not reset directly; the clear engine zeroes them.
- FSM states are INIT, IDLE and CLEAR.
  - INIT and CLEAR write 0 to address ptr, then ptr++, one word per clock.
  - When the write to ptr = DEPTH-1 completes, the FSM moves to IDLE. A clear therefore takes exactly DEPTH cycles after rst_n rises or after clr is accepted.
  - In INIT and CLEAR: ready = 0, busy = 1, and w/r/clr are ignored with no side effects.
- IDLE: ready = 1, busy = 0.
  - clr=1 enters CLEAR with ptr = 0. clr has priority; w and r in the same cycle are dropped.
  - w=1 with adr < DEPTH: for each i with be[i]=1, mem[adr] byte i <= datain byte i. Bytes with be[i]=0 are unchanged. w with be = 0 is a legal no-op write.
  - r=1 with adr < DEPTH: at the next edge dataout <= mem[adr] and rvalid = 1 for one cycle. Read latency is 1 cycle.
  - w=1 and r=1 together at the same address:
    - RDW_MODE=0: dataout = the word before the write.
    - RDW_MODE=1: dataout = the post-write merged word (per-byte mux of datain and old data under be).
    - Both modes commit the write.
  - adr >= DEPTH with w or r: the write is discarded, memory is unchanged, and the read returns dataout = 0 with rvalid = 1. err pulses 1 cycle, aligned with rvalid for reads and one cycle after the request for writes.
  - When no read is accepted, dataout holds its last value and rvalid = 0.
- Back-to-back accesses are legal every cycle in IDLE; throughput is 1 access per clock.
- Asserting rst_n low mid-clear or mid-access aborts immediately. After release the FSM restarts INIT from ptr = 0. A pending rvalid is not produced.
- Address arithmetic: ptr is AW+1 bits wide, so DEPTH = 2**AW terminates without wrap. Only adr[AW-1:0] is used; there is no implicit modulo.

Test Plan:
1. Reset release, DW=8, DEPTH=256: ready=0 and busy=1 for exactly 256 cycles, then ready=1. Read adr=0x0A -> dataout=0x00, rvalid=1 one cycle later.
2. Write adr=0x0A datain=0xFF be=1, then read 0x0A -> dataout=0xFF. Next write datain=0x55 to 0x0A, then read -> 0x55, matching the original directed sequence.
3. Byte enable, DW=32: write 0xAABBCCDD be=4'hF to adr 3, then 0x11223344 be=4'b0101 to adr 3. Read adr 3 -> 0xAA22CC44.
4. RDW collision at adr 5 holding 0x12, simultaneous w=1 r=1 datain=0x34 be=1:
   - RDW_MODE=0 -> dataout=0x12; a later read returns 0x34.
   - RDW_MODE=1 -> dataout=0x34.
5. DEPTH=200, AW=8: write adr=0xC8 datain=0x77 -> err pulse, memory unchanged. Read adr=0xC8 -> dataout=0, rvalid=1, err=1. Read adr=0xC7 -> its stored value.
6. Fill words 0..3 with nonzero data, then pulse clr with w=1 in the same cycle. The write is dropped and busy=1 for DEPTH cycles. After that, every read returns 0. Pulling rst_n low at cycle 10 of the clear restarts a full DEPTH-cycle INIT.

Source files
------------

// File: rtl/data_memory_param.sv
// Parametrised single-port synchronous data memory with byte enables, registered
// reads, selectable read-during-write behaviour and a word-per-cycle clear engine.
module data_memory_param #(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int DEPTH    = 256,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     adr,
  input  logic [DW-1:0]     datain,
  input  logic [DW/8-1:0]   be,
  input  logic              w,
  input  logic              r,
  input  logic              clr,
  output logic [DW-1:0]     dataout,
  output logic              rvalid,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int NB = DW / 8;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [AW:0]     ptr_r;
  logic [AW:0]     ptr_s;
  logic            ready_r;
  logic            busy_r;
  logic            ready_s;
  logic            busy_s;
  logic [DW-1:0]   dataout_r;
  logic            rvalid_r;
  logic            err_r;

  logic [DW-1:0]   mem [DEPTH];

  logic            idle_s;
  logic            clearing_s;
  logic            clr_last_s;
  logic            clr_go_s;
  logic            acc_w_s;
  logic            acc_r_s;
  logic            in_range_s;
  logic [DW-1:0]   old_s;
  logic [DW-1:0]   merged_s;
  logic [DW-1:0]   rd_word_s;

  // Per-byte select between the stored word and new write data.
  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [NB-1:0] en);
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (en[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Access qualification and read/merge datapath.
  always_comb begin
    idle_s     = (state_r == ST_IDLE);
    clearing_s = !idle_s;
    clr_last_s = clearing_s && (ptr_r == LAST_W);
    clr_go_s   = idle_s && clr;
    acc_w_s    = idle_s && !clr && w;
    acc_r_s    = idle_s && !clr && r;
    in_range_s = ({1'b0, adr} < DEPTH_W);
    old_s      = '0;
    if (in_range_s) begin
      old_s = mem[adr];
    end else begin
      old_s = '0;
    end
    merged_s = byte_merge(old_s, datain, be);
    if ((RDW_MODE == 1) && acc_w_s) begin
      rd_word_s = merged_s;
    end else begin
      rd_word_s = old_s;
    end
  end

  // Next-state and clear-pointer logic.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_INIT, ST_CLEAR: begin
        if (clr_last_s) begin
          state_s = ST_IDLE;
          ptr_s   = '0;
        end else begin
          state_s = state_r;
          ptr_s   = ptr_r + ONE_W;
        end
      end
      ST_IDLE: begin
        if (clr_go_s) begin
          state_s = ST_CLEAR;
          ptr_s   = '0;
        end else begin
          state_s = ST_IDLE;
          ptr_s   = ptr_r;
        end
      end
      default: begin
        state_s = ST_INIT;
        ptr_s   = '0;
      end
    endcase
  end

  // Moore outputs for the following cycle, registered alongside the state.
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b1;
    case (state_s)
      ST_IDLE: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      default: begin
        ready_s = 1'b0;
        busy_s  = 1'b1;
      end
    endcase
  end

  // State, clear pointer and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
      ptr_r   <= '0;
      ready_r <= 1'b0;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
    end
  end

  // Storage array; the clear engine owns the write port while not idle.
  always_ff @(posedge clk) begin
    if (clearing_s) begin
      mem[ptr_r[AW-1:0]] <= '0;
    end else if (acc_w_s && in_range_s) begin
      mem[adr] <= merged_s;
    end
  end

  // Registered read data, valid and out-of-range flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout_r <= '0;
      rvalid_r  <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      rvalid_r <= acc_r_s;
      err_r    <= (acc_r_s || acc_w_s) && !in_range_s;
      if (acc_r_s) begin
        dataout_r <= in_range_s ? rd_word_s : '0;
      end else begin
        dataout_r <= dataout_r;
      end
    end
  end

  assign dataout = dataout_r;
  assign rvalid  = rvalid_r;
  assign err     = err_r;
  assign ready   = ready_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_data_memory_param.sv
// Scoreboard bench: instance A (8-bit, 256 words, read-first) and
// instance B (32-bit, 200 words, write-first) driven with directed vectors.
module tb_data_memory_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_na, wa, ra, clra;
  logic [7:0] adra, dina, douta;
  logic [0:0] bea;
  logic       rva, rdya, bsya, erra;

  logic        rst_nb, wb, rb, clrb;
  logic [7:0]  adrb;
  logic [31:0] dinb, doutb;
  logic [3:0]  beb;
  logic        rvb, rdyb, bsyb, errb;

  data_memory_param #(.DW(8), .AW(8), .DEPTH(256), .RDW_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_na), .adr(adra), .datain(dina), .be(bea),
    .w(wa), .r(ra), .clr(clra), .dataout(douta), .rvalid(rva),
    .ready(rdya), .busy(bsya), .err(erra));

  data_memory_param #(.DW(32), .AW(8), .DEPTH(200), .RDW_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_nb), .adr(adrb), .datain(dinb), .be(beb),
    .w(wb), .r(rb), .clr(clrb), .dataout(doutb), .rvalid(rvb),
    .ready(rdyb), .busy(bsyb), .err(errb));

  typedef struct packed {
    logic        rd;
    logic        er;
    logic [31:0] d;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive one cycle of request inputs; optionally queue the expected response.
  task automatic acc(input int sel, input logic wv, input logic rv, input logic cv,
                     input logic [7:0] a, input logic [31:0] d, input logic [3:0] b,
                     input bit ev, input logic exp_rd, input logic [31:0] exp_d,
                     input logic exp_er);
    ev_t e;
    e.rd = exp_rd;
    e.er = exp_er;
    e.d  = exp_d;
    if (sel == 0) begin
      wa = wv; ra = rv; clra = cv; adra = a; dina = d[7:0]; bea = b[0:0];
      if (ev) qa.push_back(e);
    end else begin
      wb = wv; rb = rv; clrb = cv; adrb = a; dinb = d; beb = b;
      if (ev) qb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      wa = 1'b0; ra = 1'b0; clra = 1'b0;
    end else begin
      wb = 1'b0; rb = 1'b0; clrb = 1'b0;
    end
  endtask

  task automatic wr(input int sel, input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] b, input logic exp_er);
    acc(sel, 1'b1, 1'b0, 1'b0, a, d, b, exp_er, 1'b0, 32'h0, exp_er);
  endtask

  task automatic rd(input int sel, input logic [7:0] a, input logic [31:0] exp_d,
                    input logic exp_er);
    acc(sel, 1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, 1'b1, exp_d, exp_er);
  endtask

  task automatic clear_req(input int sel);
    acc(sel, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Count cycles with ready low (bounded) and how many of them lacked busy.
  task automatic wait_ready(input int sel, output int n, output int bad);
    n   = 0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if ((sel == 0) ? rdya : rdyb) break;
      n++;
      if (((sel == 0) ? bsya : bsyb) !== 1'b1) bad++;
    end
  endtask

  // Monitor for instance A: every rvalid or err pulse must match the queue head.
  always @(negedge clk) begin
    if (rva === 1'b1 || erra === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_output", {30'h0, rva, erra}, 32'h0);
      end else begin
        ev_t e;
        e = qa.pop_front();
        chk("a_rvalid", {31'h0, rva}, {31'h0, e.rd});
        chk("a_err", {31'h0, erra}, {31'h0, e.er});
        if (e.rd) chk("a_dataout", {24'h0, douta}, e.d);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (rvb === 1'b1 || errb === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_output", {30'h0, rvb, errb}, 32'h0);
      end else begin
        ev_t e;
        e = qb.pop_front();
        chk("b_rvalid", {31'h0, rvb}, {31'h0, e.rd});
        chk("b_err", {31'h0, errb}, {31'h0, e.er});
        if (e.rd) chk("b_dataout", doutb, e.d);
      end
    end
  end

  initial begin
    int n;
    int bad;
    rst_na = 1'b0; wa = 1'b0; ra = 1'b0; clra = 1'b0; adra = 8'h0; dina = 8'h0; bea = 1'b0;
    rst_nb = 1'b0; wb = 1'b0; rb = 1'b0; clrb = 1'b0; adrb = 8'h0; dinb = 32'h0; beb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_reset_ready", {31'h0, rdya}, 32'h0);
    chk("a_reset_busy", {31'h0, bsya}, 32'h1);
    chk("a_reset_dataout", {24'h0, douta}, 32'h0);
    rst_na = 1'b1;
    rst_nb = 1'b1;

    // A: init length, then basic writes/reads
    wait_ready(0, n, bad);
    chk("a_init_cycles", n, 256);
    chk("a_init_busy", bad, 0);
    chk("a_idle_busy", {31'h0, bsya}, 32'h0);
    rd(0, 8'h0A, 32'h00, 1'b0);
    wr(0, 8'h0A, 32'hFF, 4'h1, 1'b0);
    rd(0, 8'h0A, 32'hFF, 1'b0);
    wr(0, 8'h0A, 32'h55, 4'h1, 1'b0);
    rd(0, 8'h0A, 32'h55, 1'b0);
    wr(0, 8'h0A, 32'hAA, 4'h0, 1'b0);
    rd(0, 8'h0A, 32'h55, 1'b0);

    // A: read-first collision
    wr(0, 8'h05, 32'h12, 4'h1, 1'b0);
    acc(0, 1'b1, 1'b1, 1'b0, 8'h05, 32'h34, 4'h1, 1'b1, 1'b1, 32'h12, 1'b0);
    rd(0, 8'h05, 32'h34, 1'b0);

    // A: top address is in range when DEPTH = 2**AW
    wr(0, 8'hFF, 32'hA5, 4'h1, 1'b0);
    rd(0, 8'hFF, 32'hA5, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("a_dataout_hold", {24'h0, douta}, 32'hA5);
    chk("a_rvalid_idle", {31'h0, rva}, 32'h0);

    // A: clear with a simultaneous write/read that must be dropped
    wr(0, 8'h00, 32'h11, 4'h1, 1'b0);
    wr(0, 8'h01, 32'h22, 4'h1, 1'b0);
    wr(0, 8'h02, 32'h33, 4'h1, 1'b0);
    wr(0, 8'h03, 32'h44, 4'h1, 1'b0);
    rd(0, 8'h02, 32'h33, 1'b0);
    acc(0, 1'b1, 1'b1, 1'b1, 8'h00, 32'hEE, 4'h1, 1'b0, 1'b0, 32'h0, 1'b0);
    wait_ready(0, n, bad);
    chk("a_clear_cycles", n, 256);
    chk("a_clear_busy", bad, 0);
    for (int i = 0; i < 4; i++) rd(0, 8'(i), 32'h00, 1'b0);

    // A: requests during a clear are ignored
    clear_req(0);
    @(posedge clk);
    #1;
    acc(0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h99, 4'h1, 1'b0, 1'b0, 32'h0, 1'b0);
    wait_ready(0, n, bad);
    chk("a_clear2_cycles", n, 254);
    rd(0, 8'h00, 32'h00, 1'b0);

    // A: reset in the middle of a clear restarts a full init
    wr(0, 8'h07, 32'h77, 4'h1, 1'b0);
    rd(0, 8'h07, 32'h77, 1'b0);
    clear_req(0);
    repeat (9) @(posedge clk);
    #1;
    rst_na = 1'b0;
    @(posedge clk);
    #1;
    chk("a_midreset_ready", {31'h0, rdya}, 32'h0);
    rst_na = 1'b1;
    wait_ready(0, n, bad);
    chk("a_reinit_cycles", n, 256);
    rd(0, 8'h07, 32'h00, 1'b0);

    // B: re-run init, byte enables, write-first collision, range checks
    rst_nb = 1'b0;
    @(posedge clk);
    #1;
    rst_nb = 1'b1;
    wait_ready(1, n, bad);
    chk("b_init_cycles", n, 200);
    chk("b_init_busy", bad, 0);
    wr(1, 8'h03, 32'hAABBCCDD, 4'hF, 1'b0);
    wr(1, 8'h03, 32'h11223344, 4'b0101, 1'b0);
    rd(1, 8'h03, 32'hAA22CC44, 1'b0);
    wr(1, 8'h05, 32'h00000012, 4'hF, 1'b0);
    acc(1, 1'b1, 1'b1, 1'b0, 8'h05, 32'h00000034, 4'h1, 1'b1, 1'b1, 32'h00000034, 1'b0);
    rd(1, 8'h05, 32'h00000034, 1'b0);
    wr(1, 8'hC7, 32'h5A5A5A5A, 4'hF, 1'b0);
    wr(1, 8'hC8, 32'h00000077, 4'hF, 1'b1);
    rd(1, 8'hC8, 32'h00000000, 1'b1);
    rd(1, 8'hC7, 32'h5A5A5A5A, 1'b0);
    rd(1, 8'h03, 32'hAA22CC44, 1'b0);
    clear_req(1);
    wait_ready(1, n, bad);
    chk("b_clear_cycles", n, 200);
    rd(1, 8'hC7, 32'h00000000, 1'b0);
    rd(1, 8'h03, 32'h00000000, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
